// File: rtl/na_ctrl_pkg.sv
// na_ctrl_pkg: shared states, pump phase table and valve masks for the extraction controller
package na_ctrl_pkg;
    typedef enum logic [3:0] {
        IDLE = 4'd0, LOAD, LYSE, MIX, BIND, WASH, ELUTE, COLLECT, DONE
    } state_t;

    localparam int LYSIS      = 0;
    localparam int WASH_V     = 1;
    localparam int ELUTE_V    = 2;
    localparam int HORIZ      = 3;
    localparam int DEAD_END   = 4;
    localparam int LOOP_EXIT  = 5;
    localparam int BEAD_VTL   = 6;
    localparam int COLLECTION = 7;
    localparam int VERTICAL   = 8;
    localparam int BEAD_TRAP  = 9;

    localparam logic [2:0] PUMP_TBL [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

    // bits set here are the valves opened (driven to 0) in that state
    localparam logic [9:0] OPEN_MASK [9] = '{
        10'd0,
        10'd1 << HORIZ,
        (10'd1 << LYSIS) | (10'd1 << VERTICAL),
        10'd1 << VERTICAL,
        (10'd1 << BEAD_VTL) | (10'd1 << LOOP_EXIT),
        (10'd1 << WASH_V) | (10'd1 << LOOP_EXIT) | (10'd1 << DEAD_END),
        (10'd1 << ELUTE_V) | (10'd1 << VERTICAL),
        (10'd1 << COLLECTION) | (10'd1 << LOOP_EXIT) | (10'd1 << BEAD_TRAP),
        10'd0
    };
endpackage

// File: rtl/na_pump_seq.sv
// na_pump_seq: six-phase peristaltic pattern generator with a PUMP_DIV-cycle phase divider
module na_pump_seq
    import na_ctrl_pkg::*;
#(
    parameter int PUMP_DIV = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    output logic [2:0] pattern
);
    logic [15:0] div;
    logic [2:0]  phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= '0;
            phase <= '0;
        end else if (clear) begin
            div   <= '0;
            phase <= '0;
        end else if (enable) begin
            if (int'(div) + 1 >= PUMP_DIV) begin
                div   <= '0;
                phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
            end else begin
                div <= div + 16'd1;
            end
        end
    end

    assign pattern = PUMP_TBL[phase];
endmodule

// File: rtl/nucleic_acid_ctrl.sv
// nucleic_acid_ctrl: timed load/lyse/mix/bind/wash/elute/collect sequencer for the extraction array.
// Optional NA_CTRL_HOLD_EN adds a hold input that freezes the protocol in place.
module nucleic_acid_ctrl
    import na_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int T_LOAD    = 100,
    parameter int T_LYSE    = 200,
    parameter int T_MIX     = 400,
    parameter int T_BIND    = 200,
    parameter int T_WASH    = 100,
    parameter int T_ELUTE   = 100,
    parameter int T_COLLECT = 50,
    parameter int PUMP_DIV  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
`ifdef NA_CTRL_HOLD_EN
    input  logic       hold,
`endif
    output logic       busy,
    output logic       done,
    output logic [3:0] state_o,
    output logic       lysis_ctl,
    output logic       wash_ctl,
    output logic       elute_ctl,
    output logic       horiz_ctl,
    output logic       dead_end_ctl,
    output logic       loop_exit_ctl,
    output logic       bead_vtl_ctl,
    output logic       collection_ctl,
    output logic       vertical_ctl,
    output logic       bead_trap_ctl,
    output logic       pump1,
    output logic       pump2,
    output logic       pump3
);
    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [9:0]       valves;
    logic [2:0]       pattern;
    logic             frz;

`ifdef NA_CTRL_HOLD_EN
    assign frz = hold;
`else
    assign frz = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] dur(state_t s);
        int t;
        t = (s == LOAD)  ? T_LOAD  : (s == LYSE)  ? T_LYSE  : (s == MIX)     ? T_MIX :
            (s == BIND)  ? T_BIND  : (s == WASH)  ? T_WASH  : (s == ELUTE)   ? T_ELUTE :
            (s == COLLECT) ? T_COLLECT : 1;
        return (t <= 1) ? '0 : CNT_W'(t - 1);
    endfunction

    // start is only looked at in IDLE, so hold cannot block a launch
    always_comb begin
        nxt = abort ? IDLE :
              (state == IDLE) ? (start ? LOAD : IDLE) :
              frz ? state :
              (state == DONE) ? IDLE :
              (cnt == '0) ? state_t'(state + 4'd1) : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            valves <= '1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= (nxt != state) ? dur(nxt) : (frz || cnt == '0) ? cnt : cnt - CNT_W'(1);
            valves <= ~OPEN_MASK[nxt];
            busy   <= (nxt != IDLE) && (nxt != DONE);
            done   <= (nxt == DONE);
        end
    end

    na_pump_seq #(.PUMP_DIV(PUMP_DIV)) u_pump (
        .clk    (clk),
        .rst    (rst),
        .enable (state == MIX && nxt == MIX && !frz),
        .clear  (state != MIX && nxt == MIX),
        .pattern(pattern)
    );

    assign state_o               = state;
    assign {pump1, pump2, pump3} = (state == MIX) ? pattern : 3'b111;
    assign lysis_ctl             = valves[LYSIS];
    assign wash_ctl              = valves[WASH_V];
    assign elute_ctl             = valves[ELUTE_V];
    assign horiz_ctl             = valves[HORIZ];
    assign dead_end_ctl          = valves[DEAD_END];
    assign loop_exit_ctl         = valves[LOOP_EXIT];
    assign bead_vtl_ctl          = valves[BEAD_VTL];
    assign collection_ctl        = valves[COLLECTION];
    assign vertical_ctl          = valves[VERTICAL];
    assign bead_trap_ctl         = valves[BEAD_TRAP];
endmodule

// File: tb/tb_nucleic_acid_ctrl.sv
// tb_nucleic_acid_ctrl: directed checks of the extraction controller with shortened step timings
module tb_nucleic_acid_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, hold = 1'b0;
    logic busy, done;
    logic [3:0] state_o;
    logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, dead_end_ctl, loop_exit_ctl;
    logic bead_vtl_ctl, collection_ctl, vertical_ctl, bead_trap_ctl, pump1, pump2, pump3;
    int n_cmp = 0, n_err = 0, done_cnt = 0;

    localparam logic [9:0] OPEN [9] = '{
        10'b00_0000_0000, 10'b00_0000_1000, 10'b01_0000_0001, 10'b01_0000_0000,
        10'b00_0110_0000, 10'b00_0011_0010, 10'b01_0000_0100, 10'b10_1010_0000,
        10'b00_0000_0000
    };
    localparam logic [2:0] PT [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    localparam int DUR [9] = '{0, 3, 3, 12, 3, 3, 3, 3, 1};

    always #5 clk = ~clk;

    nucleic_acid_ctrl #(
        .CNT_W(16), .T_LOAD(3), .T_LYSE(3), .T_MIX(12), .T_BIND(3),
        .T_WASH(3), .T_ELUTE(3), .T_COLLECT(3), .PUMP_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
`ifdef NA_CTRL_HOLD_EN
        .hold(hold),
`endif
        .busy(busy), .done(done), .state_o(state_o),
        .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
        .horiz_ctl(horiz_ctl), .dead_end_ctl(dead_end_ctl), .loop_exit_ctl(loop_exit_ctl),
        .bead_vtl_ctl(bead_vtl_ctl), .collection_ctl(collection_ctl),
        .vertical_ctl(vertical_ctl), .bead_trap_ctl(bead_trap_ctl),
        .pump1(pump1), .pump2(pump2), .pump3(pump3)
    );

    always @(negedge clk) if (done) done_cnt++;

    wire [9:0]  vlv = {bead_trap_ctl, vertical_ctl, collection_ctl, bead_vtl_ctl, loop_exit_ctl,
                       dead_end_ctl, horiz_ctl, elute_ctl, wash_ctl, lysis_ctl};
    wire [2:0]  pmp = {pump1, pump2, pump3};
    wire [18:0] obs = {state_o, busy, done, vlv, pmp};

    function automatic logic [18:0] expv(int s, logic [2:0] p);
        return {4'(s), (s >= 1 && s <= 7), (s == 8), ~OPEN[s], p};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s);
        for (int i = 0; i < 100 && state_o != 4'(s); i++) step();
        chk("reach_state", 32'(state_o), s);
    endtask

    task automatic run_seq();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int s = 1; s <= 8; s++)
            for (int k = 0; k < DUR[s]; k++) begin
                chk($sformatf("walk_s%0d_k%0d", s, k), 32'(obs),
                    32'(expv(s, (s == 3) ? PT[(k / 2) % 6] : 3'b111)));
                step();
            end
        chk("walk_end_idle", 32'(obs), 32'(expv(0, 3'b111)));
    endtask

    initial begin
        int n;
        step();
        step();
        chk("in_reset", 32'(obs), 32'(expv(0, 3'b111)));
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_no_start", 32'(obs), 32'(expv(0, 3'b111)));
        end
        run_seq();
        chk("done_once", done_cnt, 1);
        // abort in the second WASH cycle
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(5);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_wash", 32'(obs), 32'(expv(0, 3'b111)));
        for (int i = 0; i < 20; i++) begin
            step();
            chk("after_abort", 32'(obs), 32'(expv(0, 3'b111)));
        end
        chk("abort_no_done", done_cnt, 1);
        run_seq();
        chk("rerun_done", done_cnt, 2);
        // start ignored mid-run; abort beats start
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("lyse_start_ign", 32'(state_o), 2);
        step();
        step();
        chk("lyse_to_mix", 32'(state_o), 3);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_with_start", 32'(obs), 32'(expv(0, 3'b111)));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("no_restart", 32'(obs), 32'(expv(0, 3'b111)));
        end
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("idle_abort_start", 32'(obs), 32'(expv(0, 3'b111)));
        // asynchronous reset in MIX
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(3);
        #2 rst = 1'b1;
        #1 chk("async_rst", 32'(obs), 32'(expv(0, 3'b111)));
        step();
        rst = 1'b0;
        step();
        chk("post_rst_idle", 32'(obs), 32'(expv(0, 3'b111)));
        chk("rst_no_done", done_cnt, 2);
`ifdef NA_CTRL_HOLD_EN
        start = 1'b1;
        step();
        start = 1'b0;
        wait_state(3);
        n = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (state_o == 4'd3) n++;
        end
        chk("hold_pre_pump", 32'(pmp), 32'(3'b101));
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (state_o == 4'd3) n++;
            chk("hold_pump", 32'(pmp), 32'(3'b101));
            chk("hold_vlv", 32'(vlv), 32'(~OPEN[3]));
        end
        hold = 1'b0;
        for (int i = 0; i < 50 && state_o == 4'd3; i++) begin
            step();
            if (state_o == 4'd3) n++;
        end
        chk("hold_mix_len", n, 17);
        wait_state(0);
        chk("hold_done", done_cnt, 3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
